// File: rtl/dcache_port_arbiter_if.sv
// Bundle of the NCPUS datapath request channels and the single dcache port.
// A core's REN/WEN is its valid; it holds REN/WEN/addr/store until its one-cycle dp_dhit.
// The arbiter's forwarded dc_dmem*EN is valid to the dcache; dc_dhit is the dcache's completion.
interface dcache_port_arbiter_if #(
    parameter int NCPUS  = 2,
    parameter int WORD_W = 32,
    parameter int ADDR_W = 32
);
    logic [NCPUS-1:0]        dp_dmemREN;
    logic [NCPUS-1:0]        dp_dmemWEN;
    logic [NCPUS-1:0]        dp_datomic;
    logic [NCPUS*ADDR_W-1:0] dp_dmemaddr;
    logic [NCPUS*WORD_W-1:0] dp_dmemstore;
    logic [NCPUS-1:0]        dp_halt;
    logic [NCPUS-1:0]        dp_dhit;
    logic [NCPUS*WORD_W-1:0] dp_dmemload;

    logic                    dc_dmemREN;
    logic                    dc_dmemWEN;
    logic [ADDR_W-1:0]       dc_dmemaddr;
    logic [WORD_W-1:0]       dc_dmemstore;
    logic                    dc_halt;
    logic                    dc_dhit;
    logic [WORD_W-1:0]       dc_dmemload;

    modport master (
        input  dp_dmemREN, dp_dmemWEN, dp_datomic, dp_dmemaddr, dp_dmemstore, dp_halt,
        input  dc_dhit, dc_dmemload,
        output dp_dhit, dp_dmemload,
        output dc_dmemREN, dc_dmemWEN, dc_dmemaddr, dc_dmemstore, dc_halt
    );

    modport slave (
        output dp_dmemREN, dp_dmemWEN, dp_datomic, dp_dmemaddr, dp_dmemstore, dp_halt,
        output dc_dhit, dc_dmemload,
        input  dp_dhit, dp_dmemload,
        input  dc_dmemREN, dc_dmemWEN, dc_dmemaddr, dc_dmemstore, dc_halt
    );
endinterface

// File: rtl/dcache_port_arbiter.sv
// Round-robin arbiter of NCPUS datapath channels onto one dcache port,
// with per-core LL/SC reservations and a merged halt.
module dcache_port_arbiter #(
    parameter int NCPUS  = 2,
    parameter int WORD_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    dcache_port_arbiter_if.master bus,
    output logic [1:0]            dbg_state
);
    localparam int GW = (NCPUS > 1) ? $clog2(NCPUS) : 1;
    localparam int LW = ADDR_W - 2;
    localparam logic [GW-1:0] LAST_RST = GW'(NCPUS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        SCFAIL = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [GW-1:0]     last_q, last_d;
    logic [GW-1:0]     win;
    logic              win_found;
    logic              win_sc;
    logic [LW-1:0]     win_word;
    logic [NCPUS-1:0]  req;
    logic [NCPUS-1:0]  link_valid_q, link_valid_d;
    logic [LW-1:0]     link_addr_q [NCPUS];
    logic [LW-1:0]     link_addr_d [NCPUS];
    logic              g_ren, g_wen, g_atomic;
    logic [ADDR_W-1:0] g_addr;
    logic [WORD_W-1:0] g_store;

    assign req         = bus.dp_dmemREN | bus.dp_dmemWEN;
    assign bus.dc_halt = &bus.dp_halt;
    assign dbg_state   = state_q;

    // The core just after the last one served is examined first.
    always_comb begin
        logic [GW-1:0] idx;
        win_found = 1'b0;
        win       = last_q;
        idx       = last_q;
        for (int k = 1; k <= NCPUS; k++) begin
            idx = GW'((int'(last_q) + k) % NCPUS);
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win       = idx;
            end
        end
    end

    always_comb begin
        int wi;
        wi       = int'(win);
        win_sc   = bus.dp_dmemWEN[win] & bus.dp_datomic[win];
        win_word = bus.dp_dmemaddr[wi*ADDR_W + 2 +: LW];
    end

    always_comb begin
        int gi;
        gi       = int'(grant_q);
        g_ren    = bus.dp_dmemREN[grant_q];
        g_wen    = bus.dp_dmemWEN[grant_q];
        g_atomic = bus.dp_datomic[grant_q];
        g_addr   = bus.dp_dmemaddr[gi*ADDR_W +: ADDR_W];
        g_store  = bus.dp_dmemstore[gi*WORD_W +: WORD_W];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_q       <= LAST_RST;
            link_valid_q <= '0;
            for (int i = 0; i < NCPUS; i++) begin
                link_addr_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_q       <= last_d;
            link_valid_q <= link_valid_d;
            link_addr_q  <= link_addr_d;
        end
    end

    always_comb begin
        int gi;
        gi               = int'(grant_q);
        state_d          = state_q;
        grant_d          = grant_q;
        last_d           = last_q;
        link_valid_d     = link_valid_q;
        link_addr_d      = link_addr_q;
        bus.dp_dhit      = '0;
        bus.dp_dmemload  = '0;
        bus.dc_dmemREN   = 1'b0;
        bus.dc_dmemWEN   = 1'b0;
        bus.dc_dmemaddr  = '0;
        bus.dc_dmemstore = '0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_d = win;
                    // An SC is resolved at grant time; a failing one never reaches the dcache.
                    if (win_sc && !(link_valid_q[win] && (link_addr_q[win] == win_word))) begin
                        state_d = SCFAIL;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                bus.dc_dmemREN   = g_ren;
                bus.dc_dmemWEN   = g_wen;
                bus.dc_dmemaddr  = g_addr;
                bus.dc_dmemstore = g_store;
                if (bus.dc_dhit) begin
                    bus.dp_dhit[grant_q] = 1'b1;
                    if (g_ren) begin
                        bus.dp_dmemload[gi*WORD_W +: WORD_W] = bus.dc_dmemload;
                    end else if (g_atomic) begin
                        bus.dp_dmemload[gi*WORD_W +: WORD_W] = WORD_W'(1);
                    end
                    if (g_ren && g_atomic) begin
                        link_valid_d[grant_q] = 1'b1;
                        link_addr_d[grant_q]  = g_addr[ADDR_W-1:2];
                    end
                    if (g_wen) begin
                        for (int j = 0; j < NCPUS; j++) begin
                            if (link_addr_q[j] == g_addr[ADDR_W-1:2]) begin
                                link_valid_d[j] = 1'b0;
                            end
                        end
                        if (g_atomic) begin
                            link_valid_d[grant_q] = 1'b0;
                        end
                    end
                    last_d  = grant_q;
                    state_d = IDLE;
                end
            end
            SCFAIL: begin
                bus.dp_dhit[grant_q]  = 1'b1;
                link_valid_d[grant_q] = 1'b0;
                last_d                = grant_q;
                state_d               = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: doc/dcache_port_arbiter.md
Name: dcache_port_arbiter

Overview:
- Parametrised multi-core successor to the single datapath/dcache port.
- Arbitrates NCPUS datapath data-memory request channels onto one dcache port using round-robin arbitration.
- Adds per-core load-link/store-conditional (datomic) reservation tracking, which the single-core port does not provide.
- Sits between the NCPUS datapaths and the shared dcache.
- Also merges the per-core halt signals into one halt to the cache.

Parameters:
- NCPUS, 2, number of requesting datapath channels (>=1).
- WORD_W, 32, data width of store/load words.
- ADDR_W, 32, byte address width.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- dp_dmemREN  in  NCPUS  per-core read request.
- dp_dmemWEN  in  NCPUS  per-core write request.
- dp_datomic  in  NCPUS  per-core atomic qualifier: REN+datomic=LL, WEN+datomic=SC.
- dp_dmemaddr  in  NCPUS*ADDR_W  per-core address; core i occupies bits [i*ADDR_W +: ADDR_W].
- dp_dmemstore  in  NCPUS*WORD_W  per-core store data.
- dp_halt  in  NCPUS  per-core halt.
- dp_dhit  out  NCPUS  one-cycle completion pulse to core i.
- dp_dmemload  out  NCPUS*WORD_W  per-core load/SC-result data; valid only while dp_dhit[i] is high.
- dc_dmemREN  out  1  read request to dcache.
- dc_dmemWEN  out  1  write request to dcache.
- dc_dmemaddr  out  ADDR_W  address to dcache.
- dc_dmemstore  out  WORD_W  store data to dcache.
- dc_halt  out  1  AND of dp_halt.
- dc_dhit  in  1  dcache completion.
- dc_dmemload  in  WORD_W  dcache read data.

Behaviour:
Core rules:
- Cores hold REN/WEN/addr/store stable until they receive dp_dhit.
- REN and WEN asserted together on one core is illegal and is not checked.
- States:
  - IDLE: no grant.
  - BUSY: grant g is forwarded to the dcache.
  - SCFAIL: one-cycle failure response.

IDLE:
- Scan cores in order (last+1)..(last+NCPUS) mod NCPUS. The first core with REN|WEN wins and is registered as g.
- If the winner is an SC and its reservation is invalid, or its link address differs from its dmemaddr: go to SCFAIL.
- Otherwise go to BUSY.
- With no requests, stay in IDLE.

BUSY:
- Drive dc_dmemREN, dc_dmemWEN, dc_dmemaddr and dc_dmemstore combinationally from core g.
- On dc_dhit:
  - Pulse dp_dhit[g].
  - dp_dmemload[g] = dc_dmemload for reads; 1 for a successful SC; 0 for a plain write.
  - Set last=g and return to IDLE.

SCFAIL:
- Downstream stays idle.
- Pulse dp_dhit[g] with dp_dmemload[g]=0.
- Clear g's reservation, set last=g and return to IDLE.

Latency:
- Minimum issue latency is 1 cycle from request to dc_dmem*EN.
- Minimum completion is 2 cycles when the dcache hits immediately.
- An SC failure completes in 2 cycles with no dcache access.

Reservations:
- Per core: link_valid[i] and link_addr[i].
- LL completion sets link_valid[g]=1 and link_addr[g]=addr.
- Any write completion (plain or successful SC) from core g to address A:
  - clears link_valid[j] for every core j with link_addr[j]==A, including g itself.
  - a successful SC also clears g's own reservation.
- Address comparison uses the word address: bits [ADDR_W-1:2].
- A new LL overwrites the prior reservation of that core.

Outputs:
- Outputs not granted: dp_dhit=0 and dp_dmemload=0.
- Downstream outputs are 0 in IDLE and SCFAIL.
- dc_halt is combinational: &dp_halt.

Reset:
- Asserting RST at any time, including mid-BUSY, forces IDLE, last=NCPUS-1 (so core 0 wins first), and clears all link_valid.
- All outputs drop to 0 asynchronously.
- An in-flight dcache access is abandoned; the dcache is reset in parallel.

Boundary cases:
- NCPUS=1 degenerates to pass-through plus 1 cycle of grant latency.
- Round-robin wrap from NCPUS-1 to 0 is required.
- dc_dhit while in IDLE or SCFAIL is ignored.

Test Plan:
- NCPUS=2; core0 REN addr 0x100 alone; dcache hits after 3 cycles with 0xDEADBEEF -> dc_dmemREN rises 1 cycle after the request; dp_dhit[0] pulses once with dp_dmemload[0]=0xDEADBEEF; dp_dhit[1]=0 throughout.
- Both cores REN continuously after reset -> grants alternate 0,1,0,1; neither core is serviced twice in a row; wrap from core 1 to core 0 is verified.
- Core0 LL 0x200, then core0 SC 0x200 data 5 -> dcache write of 5 occurs; dp_dmemload[0]=1; a repeated SC 0x200 then fails with dmemload=0 and no dc_dmemWEN.
- Core0 LL 0x200; core1 plain write 0x200; then core0 SC 0x200 -> SCFAIL; dp_dhit[0] 2 cycles after request with dp_dmemload[0]=0; dc_dmemWEN never asserted for core0.
- Core0 LL 0x200; core1 write 0x204 (different word); core0 SC 0x200 -> succeeds, returns 1.
- RST asserted mid-BUSY, then released; core0 SC 0x200 -> all outputs 0 immediately on reset; SC fails, since the reservation was cleared by reset; dp_halt=2'b11 drives dc_halt=1, and 2'b01 drives dc_halt=0.
